// File: rtl/mp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mp_seq : multi-word ADD/SUB/AND/OR sequencer driving an external         |
// |          combinational N-bit ALU one word per cycle.                     |
// | Optional macro MP_SEQ_CARRY_IN_EN adds the ext_cin carry/borrow input.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mp_seq #(
   parameter int              N     = 8,
   parameter int              W     = 4,
   parameter int              AC_N  = 3,
   parameter logic [AC_N-1:0] CS_AD = AC_N'(0),
   parameter logic [AC_N-1:0] CS_AN = AC_N'(1),
   parameter logic [AC_N-1:0] CS_OR = AC_N'(2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef MP_SEQ_CARRY_IN_EN
   input  logic              ext_cin,
`endif
   input  logic [1:0]        op,
   input  logic [W*N-1:0]    a_in,
   input  logic [W*N-1:0]    b_in,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic              alu_cin,
   output logic [AC_N-1:0]   alu_cs,
   input  logic [N-1:0]      alu_s,
   input  logic              alu_zero,
   input  logic              alu_cout,
   output logic [W*N-1:0]    result,
   output logic              carry,
   output logic              zero,
   output logic              busy,
   output logic              done
);

   localparam int         KW     = (W > 1) ? $clog2(W) : 1;
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic [N-1:0]    a_r [W];
   logic [N-1:0]    b_r [W];
   logic [1:0]      op_r;
   logic            cin_r;
   logic            zacc;
   logic            init_cin;
   logic            arith;

   // Initial carry of word 0; SUB feeds ~B, so carry 1 means "no borrow".
   always_comb begin
`ifdef MP_SEQ_CARRY_IN_EN
      init_cin = (op == OP_SUB) ? ~ext_cin : ext_cin;
`else
      init_cin = (op == OP_SUB);
`endif
   end

   assign arith = (op_r == OP_ADD) || (op_r == OP_SUB);

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_cin = 1'b0;
      alu_cs  = CS_AD;
      if (state == RUN) begin
         alu_a   = a_r[k];
         alu_b   = (op_r == OP_SUB) ? ~b_r[k] : b_r[k];
         alu_cin = arith & cin_r;
         case (op_r)
            OP_AND:  alu_cs = CS_AN;
            OP_OR:   alu_cs = CS_OR;
            default: alu_cs = CS_AD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= '0;
         for (int i = 0; i < W; i++) begin
            a_r[i] <= '0;
            b_r[i] <= '0;
         end
         op_r   <= OP_ADD;
         cin_r  <= 1'b0;
         zacc   <= 1'b1;
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               for (int i = 0; i < W; i++) begin
                  a_r[i] <= a_in[i*N +: N];
                  b_r[i] <= b_in[i*N +: N];
               end
               op_r  <= op;
               k     <= '0;
               cin_r <= init_cin;
               zacc  <= 1'b1;
               busy  <= 1'b1;
               state <= RUN;
            end
         end else begin
            // Result words are replaced one per cycle as the ALU produces them.
            result[int'(k)*N +: N] <= alu_s;
            cin_r <= alu_cout;
            zacc  <= zacc & alu_zero;
            if (k == KW'(W-1)) begin
               carry <= arith ? alu_cout : 1'b0;
               zero  <= zacc & alu_zero;
               k     <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end else begin
               k <= k + KW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mp_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mp_seq : directed testbench for mp_seq with a behavioural ALU model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mp_seq;

   localparam int              N     = 8;
   localparam int              W     = 4;
   localparam int              AC_N  = 3;
   localparam logic [AC_N-1:0] CS_AD = 3'd1;
   localparam logic [AC_N-1:0] CS_AN = 3'd2;
   localparam logic [AC_N-1:0] CS_OR = 3'd5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            ext_cin = 1'b0;
   logic [1:0]      op = 2'd0;
   logic [W*N-1:0]  a_in = '0;
   logic [W*N-1:0]  b_in = '0;
   logic [N-1:0]    alu_a, alu_b, alu_s;
   logic            alu_cin, alu_zero, alu_cout;
   logic [AC_N-1:0] alu_cs;
   logic [W*N-1:0]  result;
   logic            carry, zero, busy, done;

   int checks = 0;
   int errors = 0;

   mp_seq #(.N(N), .W(W), .AC_N(AC_N), .CS_AD(CS_AD), .CS_AN(CS_AN), .CS_OR(CS_OR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MP_SEQ_CARRY_IN_EN
      .ext_cin(ext_cin),
`endif
      .op(op), .a_in(a_in), .b_in(b_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_cs(alu_cs),
      .alu_s(alu_s), .alu_zero(alu_zero), .alu_cout(alu_cout),
      .result(result), .carry(carry), .zero(zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_s    = '0;
      alu_cout = 1'b0;
      alu_zero = 1'b0;
      if (alu_cs == CS_AD)
         {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      else if (alu_cs == CS_AN)
         alu_s = alu_a & alu_b;
      else if (alu_cs == CS_OR)
         alu_s = alu_a | alu_b;
      alu_zero = (alu_s == '0);
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, output bit ok, output int lat, output int bcnt);
      @(negedge clk);
      op = o; a_in = a; b_in = b; ext_cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ok = 1'b0; lat = 0; bcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (result !== '0)   begin errors++; $display("FAIL rst_result got %h exp 0", result); end
      checks++; if (carry !== 1'b0)  begin errors++; $display("FAIL rst_carry got %b exp 0", carry); end
      checks++; if (zero !== 1'b1)   begin errors++; $display("FAIL rst_zero got %b exp 1", zero); end
      checks++; if ({alu_a, alu_b, alu_cin} !== 17'd0)
         begin errors++; $display("FAIL rst_alu_ops got %h %h %b exp 0", alu_a, alu_b, alu_cin); end
      checks++; if (alu_cs !== CS_AD) begin errors++; $display("FAIL rst_alu_cs got %h exp %h", alu_cs, CS_AD); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      bit ok; int lat, bcnt;
      run_op(2'd0, 32'h000000FF, 32'h00000001, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL add1_done got timeout exp done"); end
      checks++; if (lat != W) begin errors++; $display("FAIL add1_latency got %0d exp %0d", lat, W); end
      checks++; if (bcnt != W) begin errors++; $display("FAIL add1_busy_cycles got %0d exp %0d", bcnt, W); end
      checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL add1_result got %h exp 00000100", result); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add1_carry got %b exp 0", carry); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add1_zero got %b exp 0", zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add1_done_pulse got %b exp 0", done); end
      run_op(2'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL add2_done got timeout exp done"); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL add2_result got %h exp 00000000", result); end
      checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add2_carry got %b exp 1", carry); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add2_zero got %b exp 1", zero); end
   endtask

   task automatic test_sub();
      bit ok; int lat, bcnt;
      @(negedge clk);
      op = 2'd1; a_in = 32'h0; b_in = 32'h00000001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (alu_b !== 8'hFE) begin errors++; $display("FAIL sub_alu_b0 got %h exp fe", alu_b); end
      checks++; if (alu_cin !== 1'b1) begin errors++; $display("FAIL sub_alu_cin0 got %b exp 1", alu_cin); end
      checks++; if (alu_cs !== CS_AD) begin errors++; $display("FAIL sub_alu_cs got %h exp %h", alu_cs, CS_AD); end
      @(posedge clk); #1;
      checks++; if (alu_b !== 8'hFF) begin errors++; $display("FAIL sub_alu_b1 got %h exp ff", alu_b); end
      checks++; if (alu_cin !== 1'b0) begin errors++; $display("FAIL sub_alu_cin1 got %b exp 0", alu_cin); end
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(posedge clk); #1;
         if (done) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL sub1_done got timeout exp done"); end
      checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub1_result got %h exp ffffffff", result); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub1_carry got %b exp 0", carry); end
      run_op(2'd1, 32'h12345678, 32'h12345678, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL sub2_done got timeout exp done"); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL sub2_result got %h exp 00000000", result); end
      checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub2_carry got %b exp 1", carry); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub2_zero got %b exp 1", zero); end
   endtask

   task automatic test_logic_busy_start();
      bit ok; int lat, bcnt, dcount;
      logic [31:0] res_at_done;
      logic        carry_at_done;
      @(negedge clk);
      op = 2'd2; a_in = 32'hF0F0F0F0; b_in = 32'h0FF00FF0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (alu_cs !== CS_AN) begin errors++; $display("FAIL and_alu_cs got %h exp %h", alu_cs, CS_AN); end
      checks++; if ({alu_a, alu_b, alu_cin} !== {8'hF0, 8'hF0, 1'b0})
         begin errors++; $display("FAIL and_alu_ops got %h %h %b exp f0 f0 0", alu_a, alu_b, alu_cin); end
      @(posedge clk); #1;
      op = 2'd3; a_in = 32'hFFFFFFFF; b_in = 32'h12345678; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dcount = 0; res_at_done = '0; carry_at_done = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            dcount++;
            res_at_done = result;
            carry_at_done = carry;
         end
         @(posedge clk); #1;
      end
      checks++; if (dcount != 1) begin errors++; $display("FAIL and_done_count got %0d exp 1", dcount); end
      checks++; if (res_at_done !== 32'h00F000F0) begin errors++; $display("FAIL and_result got %h exp 00f000f0", res_at_done); end
      checks++; if (carry_at_done !== 1'b0) begin errors++; $display("FAIL and_carry got %b exp 0", carry_at_done); end
      run_op(2'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL or_done got timeout exp done"); end
      checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL or_result got %h exp ffffffff", result); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL or_carry got %b exp 0", carry); end
   endtask

   task automatic test_back_to_back();
      bit ok; int lat, bcnt;
      run_op(2'd0, 32'h11111111, 32'h11111111, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done got timeout exp done"); end
      op = 2'd0; a_in = 32'h01010101; b_in = 32'h01010101; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", busy); end
      checks++; if (result !== 32'h22222222) begin errors++; $display("FAIL b2b_hold got %h exp 22222222", result); end
      @(posedge clk); #1;
      checks++; if (result !== 32'h22222202) begin errors++; $display("FAIL b2b_word0 got %h exp 22222202", result); end
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (done) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done got timeout exp done"); end
      checks++; if (result !== 32'h02020202) begin errors++; $display("FAIL b2b_result got %h exp 02020202", result); end
   endtask

   task automatic test_reset_abort();
      bit ok; int lat, bcnt, dcount;
      @(negedge clk);
      op = 2'd0; a_in = 32'h01020304; b_in = 32'h01010101; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (result !== '0) begin errors++; $display("FAIL abort_result got %h exp 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL abort_zero got %b exp 1", zero); end
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      checks++; if (dcount != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dcount); end
      run_op(2'd0, 32'h00000001, 32'h00000001, 1'b0, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL abort_next_done got timeout exp done"); end
      checks++; if (result !== 32'h00000002) begin errors++; $display("FAIL abort_next_result got %h exp 00000002", result); end
   endtask

`ifdef MP_SEQ_CARRY_IN_EN
   task automatic test_carry_in();
      bit ok; int lat, bcnt;
      run_op(2'd0, 32'h00000001, 32'h00000001, 1'b1, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL cin_add_done got timeout exp done"); end
      checks++; if (result !== 32'h00000003) begin errors++; $display("FAIL cin_add_result got %h exp 00000003", result); end
      run_op(2'd1, 32'h00000005, 32'h00000002, 1'b1, ok, lat, bcnt);
      checks++; if (!ok) begin errors++; $display("FAIL cin_sub_done got timeout exp done"); end
      checks++; if (result !== 32'h00000002) begin errors++; $display("FAIL cin_sub_result got %h exp 00000002", result); end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic_busy_start();
      test_back_to_back();
      test_reset_abort();
`ifdef MP_SEQ_CARRY_IN_EN
      test_carry_in();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
